// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned STATE_W              = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/receiver_if.sv
// Bundle of the receiver's line input and received-byte outputs.
interface receiver_if;
    import uart_pkg::*;

    logic                 serial;
    logic [DATA_BITS-1:0] trans;
    logic                 valid;
    logic                 frame_err;

    // Line driver side (transmitter / bench)
    modport master (output serial, input trans, input valid, input frame_err);
    // Receiver side
    modport slave  (input serial, output trans, output valid, output frame_err);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to idle-high.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Metastability-settling chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// 8N1 UART receiver: mid-bit sampling, registered valid / frame_err pulses.
module receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 serial,
    input  logic                 clk,
    output logic [DATA_BITS-1:0] trans,
    input  logic                 rst_n,
    output logic                 valid,
    output logic                 frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 s;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] trans_q, trans_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 armed_q, armed_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (serial),
        .q     (s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            trans_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            trans_q <= trans_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    // Next-state and output logic; armed_q blocks restart while a break holds the line low
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        trans_d = trans_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = s;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    armed_d = s;
                    if (s) begin
                        trans_d = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign trans     = trans_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver at 16 clocks per bit (clock period 10 time units).
module tb_receiver;
    import uart_pkg::*;

    localparam int unsigned BIT_T      = 160;
    localparam int unsigned BIT_T_FAST = 152;
    localparam int unsigned BIT_T_SLOW = 168;

    logic clk = 1'b0;
    logic rst_n;

    receiver_if bus ();

    receiver #(.CLKS_PER_BIT(16)) dut (
        .serial    (bus.serial),
        .clk       (clk),
        .trans     (bus.trans),
        .rst_n     (rst_n),
        .valid     (bus.valid),
        .frame_err (bus.frame_err)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    int start_cyc = 0;
    int last_valid_cyc = 0;
    logic [7:0] vals[$];

    // Cycle counter
    always @(posedge clk) cyc++;

    // Pulse monitor sampled mid-cycle
    always @(negedge clk) begin
        if (bus.valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            vals.push_back(bus.trans);
        end
        if (bus.frame_err) n_ferr++;
        if (bus.valid && bus.frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int unsigned per);
        bus.serial = b;
        #(per);
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level (left on the line)
    task automatic send_frame(input logic [7:0] b, input int unsigned per, input logic stop);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop, per);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] partial;
        partial = 8'h5A;
        bus.serial = 1'b1;
        rst_n = 1'b0;
        idle(4);
        check("reset_trans", 32'(bus.trans), 32'h00);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_ferr",  32'(bus.frame_err), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        idle(5);

        // Single 0xA5 frame; valid expected 2 sync + 1 detect + 8 + 9*16 = 155 clocks after the start edge
        @(negedge clk);
        start_cyc = cyc;
        send_frame(8'hA5, BIT_T, 1'b1);
        idle(20);
        check("a5_valid_cnt", 32'(n_valid), 32'd1);
        check("a5_trans",     32'(bus.trans), 32'hA5);
        check("a5_latency",   32'(last_valid_cyc - start_cyc), 32'd155);
        check("a5_ferr_cnt",  32'(n_ferr), 32'd0);

        // Back-to-back 0x00 then 0xFF with no idle gap
        @(negedge clk);
        send_frame(8'h00, BIT_T, 1'b1);
        send_frame(8'hFF, BIT_T, 1'b1);
        idle(20);
        check("b2b_valid_cnt", 32'(n_valid), 32'd3);
        check("b2b_first",     32'(vals[1]), 32'h00);
        check("b2b_second",    32'(vals[2]), 32'hFF);
        check("b2b_trans",     32'(bus.trans), 32'hFF);
        check("b2b_ferr_cnt",  32'(n_ferr), 32'd0);

        // 4-clock low glitch is a false start
        @(negedge clk);
        bus.serial = 1'b0;
        #40;
        bus.serial = 1'b1;
        idle(30);
        check("glitch_valid_cnt", 32'(n_valid), 32'd3);
        check("glitch_ferr_cnt",  32'(n_ferr), 32'd0);
        check("glitch_trans",     32'(bus.trans), 32'hFF);
        check("glitch_state",     32'(dut.state_q), 32'(ST_IDLE));

        // 0x3C with low stop bit, line then held low as a break
        @(negedge clk);
        send_frame(8'h3C, BIT_T, 1'b0);
        idle(20);
        check("ferr_cnt",       32'(n_ferr), 32'd1);
        check("ferr_valid_cnt", 32'(n_valid), 32'd3);
        check("ferr_trans",     32'(bus.trans), 32'hFF);
        idle(400);
        check("break_ferr_cnt",  32'(n_ferr), 32'd1);
        check("break_valid_cnt", 32'(n_valid), 32'd3);
        check("break_state",     32'(dut.state_q), 32'(ST_IDLE));
        bus.serial = 1'b1;
        idle(20);
        @(negedge clk);
        send_frame(8'h81, BIT_T, 1'b1);
        idle(20);
        check("after_break_valid_cnt", 32'(n_valid), 32'd4);
        check("after_break_trans",     32'(bus.trans), 32'h81);
        check("after_break_ferr_cnt",  32'(n_ferr), 32'd1);

        // Reset asserted in the middle of data bit 4
        @(negedge clk);
        drive_bit(1'b0, BIT_T);
        for (int i = 0; i < 4; i++) drive_bit(partial[i], BIT_T);
        bus.serial = partial[4];
        #80;
        rst_n = 1'b0;
        #1;
        check("midrst_trans", 32'(bus.trans), 32'h00);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_ferr",  32'(bus.frame_err), 32'h0);
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        bus.serial = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(300);
        check("midrst_no_pulse_valid", 32'(n_valid), 32'd4);
        check("midrst_no_pulse_ferr",  32'(n_ferr), 32'd1);
        @(negedge clk);
        send_frame(8'h5A, BIT_T, 1'b1);
        idle(20);
        check("post_rst_valid_cnt", 32'(n_valid), 32'd5);
        check("post_rst_trans",     32'(bus.trans), 32'h5A);

        // +/-5% bit-rate skew on 0x96, separated by a 0x3C frame
        @(negedge clk);
        send_frame(8'h96, BIT_T_FAST, 1'b1);
        idle(30);
        check("fast_valid_cnt", 32'(n_valid), 32'd6);
        check("fast_trans",     32'(bus.trans), 32'h96);
        @(negedge clk);
        send_frame(8'h3C, BIT_T, 1'b1);
        idle(30);
        check("mid_trans", 32'(bus.trans), 32'h3C);
        @(negedge clk);
        send_frame(8'h96, BIT_T_SLOW, 1'b1);
        idle(30);
        check("slow_valid_cnt", 32'(n_valid), 32'd8);
        check("slow_trans",     32'(bus.trans), 32'h96);
        check("skew_ferr_cnt",  32'(n_ferr), 32'd1);
        check("never_both",     32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
